// File: rtl/rename_stage.sv
// Register-rename stage: maps decoded architectural operands through a RAT onto
// physical tags, allocating destinations from a circular free list.
module rename_stage #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int PREG_W    = 6,
  parameter int CTRL_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic              in_rd_wr,
  input  logic [31:0]       in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PREG_W-1:0] out_prs1,
  output logic [PREG_W-1:0] out_prs2,
  output logic [PREG_W-1:0] out_prd,
  output logic [PREG_W-1:0] out_old_prd,
  output logic              out_rd_wr,
  output logic [31:0]       out_imm,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              free_valid,
  input  logic [PREG_W-1:0] free_preg
);

  localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int FL_PTR_W = $clog2(FL_DEPTH);
  localparam int CNT_W    = FL_PTR_W + 1;

  function automatic logic [FL_PTR_W-1:0] ptr_inc(input logic [FL_PTR_W-1:0] ptr);
    return ptr + FL_PTR_W'(1);
  endfunction

  logic [PREG_W-1:0]   rat       [ARCH_REGS];
  logic [PREG_W-1:0]   free_list [FL_DEPTH];
  logic [FL_PTR_W-1:0] head;
  logic [FL_PTR_W-1:0] tail;
  logic [CNT_W-1:0]    count;

  logic need_alloc;
  logic fl_empty;
  logic fl_full;
  logic accept;
  logic alloc;
  logic free_ok;

  logic [PREG_W-1:0] prs1_p0;
  logic [PREG_W-1:0] prs2_p0;
  logic [PREG_W-1:0] prd_p0;
  logic [PREG_W-1:0] old_prd_p0;

  logic              vld_p1;
  logic [PREG_W-1:0] prs1_p1;
  logic [PREG_W-1:0] prs2_p1;
  logic [PREG_W-1:0] prd_p1;
  logic [PREG_W-1:0] old_prd_p1;
  logic              rd_wr_p1;
  logic [31:0]       imm_p1;
  logic [CTRL_W-1:0] ctrl_p1;

  // Stage p0: combinational RAT / free-list lookup
  always_comb begin
    need_alloc = in_rd_wr && (in_rd != 5'd0);
    fl_empty   = (count == '0);
    fl_full    = (count == CNT_W'(FL_DEPTH));
    // A free arriving this cycle cannot unblock an empty list until next cycle.
    in_ready   = (!vld_p1 || out_ready) && (!need_alloc || !fl_empty);
    accept     = in_valid && in_ready;
    alloc      = accept && need_alloc;
    free_ok    = free_valid && (free_preg != '0) && !fl_full;
    prs1_p0    = rat[in_rs1];
    prs2_p0    = rat[in_rs2];
    prd_p0     = need_alloc ? free_list[head] : '0;
    old_prd_p0 = need_alloc ? rat[in_rd] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) rat[i] <= PREG_W'(i);
      for (int i = 0; i < FL_DEPTH; i++) free_list[i] <= PREG_W'(ARCH_REGS + i);
      head  <= '0;
      tail  <= '0;
      count <= CNT_W'(FL_DEPTH);
    end else begin
      if (alloc) begin
        rat[in_rd] <= free_list[head];
        head       <= ptr_inc(head);
      end
      if (free_ok) begin
        free_list[tail] <= free_preg;
        tail            <= ptr_inc(tail);
      end
      case ({alloc, free_ok})
        2'b10:   count <= count - CNT_W'(1);
        2'b01:   count <= count + CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Stage p1: output register toward dispatch
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      prs1_p1    <= '0;
      prs2_p1    <= '0;
      prd_p1     <= '0;
      old_prd_p1 <= '0;
      rd_wr_p1   <= 1'b0;
      imm_p1     <= '0;
      ctrl_p1    <= '0;
    end else if (accept) begin
      vld_p1     <= 1'b1;
      prs1_p1    <= prs1_p0;
      prs2_p1    <= prs2_p0;
      prd_p1     <= prd_p0;
      old_prd_p1 <= old_prd_p0;
      rd_wr_p1   <= need_alloc;
      imm_p1     <= in_imm;
      ctrl_p1    <= in_ctrl;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && free_valid && (free_preg != '0))
      assert (!fl_full) else $error("rename_stage: free return with full free list");
  end

  assign out_valid   = vld_p1;
  assign out_prs1    = prs1_p1;
  assign out_prs2    = prs2_p1;
  assign out_prd     = prd_p1;
  assign out_old_prd = old_prd_p1;
  assign out_rd_wr   = rd_wr_p1;
  assign out_imm     = imm_p1;
  assign out_ctrl    = ctrl_p1;

endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage: vector table plus hand sequences for
// free-list exhaustion, output stall and mid-stream reset.
module tb_rename_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rd_wr;
  logic [31:0] in_imm;
  logic [7:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_prs1, out_prs2, out_prd, out_old_prd;
  logic        out_rd_wr;
  logic [31:0] out_imm;
  logic [7:0]  out_ctrl;
  logic        free_valid;
  logic [5:0]  free_preg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rename_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wr(in_rd_wr),
    .in_imm(in_imm), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd),
    .out_old_prd(out_old_prd), .out_rd_wr(out_rd_wr),
    .out_imm(out_imm), .out_ctrl(out_ctrl),
    .free_valid(free_valid), .free_preg(free_preg)
  );

  typedef struct {
    logic        vld;
    logic [4:0]  rs1, rs2, rd;
    logic        wr;
    logic [31:0] imm;
    logic [7:0]  ctrl;
    logic        ordy;
    logic        e_irdy, e_ovld;
    logic [5:0]  e_prs1, e_prs2, e_prd, e_old;
    logic        e_wr;
    logic [31:0] e_imm;
    logic [7:0]  e_ctrl;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] d, input logic w, input logic ordy,
                       input logic fv, input logic [5:0] fp);
    in_valid = v; in_rs1 = r1; in_rs2 = r2; in_rd = d; in_rd_wr = w;
    out_ready = ordy; free_valid = fv; free_preg = fp;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 6'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One accepted-or-not step: drive at negedge, check in_ready, check outputs after edge.
  task automatic alloc_step(input string nm, input int idx, input logic [4:0] d,
                            input logic e_irdy, input logic [5:0] e_prd);
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, d, 1'b1, 1'b1, 1'b0, 6'd0);
    #1 chk({nm, "_irdy"}, idx, 32'(in_ready), 32'(e_irdy));
    @(posedge clk); #1;
    if (e_irdy) chk({nm, "_prd"}, idx, 32'(out_prd), 32'(e_prd));
    else        chk({nm, "_ovld"}, idx, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_imm = '0; in_ctrl = '0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 6'd0);

    //             vld rs1 rs2 rd wr imm            ctrl  ordy irdy ovld prs1 prs2 prd old wr e_imm          e_ctrl
    vecs[0]  = '{1, 1,  2,  3, 1, 32'h0000_1234, 8'hA5, 1, 1, 1,  1,  2, 32,  3, 1, 32'h0000_1234, 8'hA5};
    vecs[1]  = '{1, 4,  5,  3, 1, 32'hFFFF_FFFF, 8'h01, 1, 1, 1,  4,  5, 33, 32, 1, 32'hFFFF_FFFF, 8'h01};
    vecs[2]  = '{1, 3,  3,  6, 1, 32'h0000_0000, 8'h02, 1, 1, 1, 33, 33, 34,  6, 1, 32'h0000_0000, 8'h02};
    vecs[3]  = '{1, 6,  0,  6, 1, 32'h8000_0000, 8'h03, 1, 1, 1, 34,  0, 35, 34, 1, 32'h8000_0000, 8'h03};
    vecs[4]  = '{1, 3,  6,  0, 1, 32'h0000_0005, 8'h04, 1, 1, 1, 33, 35,  0,  0, 0, 32'h0000_0005, 8'h04};
    vecs[5]  = '{1, 7,  8,  7, 0, 32'h0000_0006, 8'h05, 1, 1, 1,  7,  8,  0,  0, 0, 32'h0000_0006, 8'h05};
    vecs[6]  = '{1, 31, 9,  9, 1, 32'h0000_0007, 8'h06, 1, 1, 1, 31,  9, 36,  9, 1, 32'h0000_0007, 8'h06};
    vecs[7]  = '{0, 0,  0,  0, 0, 32'h0000_0000, 8'h00, 1, 1, 0, 31,  9, 36,  9, 1, 32'h0000_0007, 8'h06};
    vecs[8]  = '{1, 2,  0,  0, 0, 32'h0000_0009, 8'h09, 0, 1, 1,  2,  0,  0,  0, 0, 32'h0000_0009, 8'h09};
    vecs[9]  = '{1, 5,  5,  5, 1, 32'h0000_000A, 8'h0A, 0, 0, 1,  2,  0,  0,  0, 0, 32'h0000_0009, 8'h09};
    vecs[10] = '{1, 5,  5,  5, 1, 32'h0000_000A, 8'h0A, 1, 1, 1,  5,  5, 37,  5, 1, 32'h0000_000A, 8'h0A};
    vecs[11] = '{0, 0,  0,  0, 0, 32'h0000_0000, 8'h00, 0, 0, 1,  5,  5, 37,  5, 1, 32'h0000_000A, 8'h0A};
    vecs[12] = '{0, 0,  0,  0, 0, 32'h0000_0000, 8'h00, 1, 1, 0,  5,  5, 37,  5, 1, 32'h0000_000A, 8'h0A};

    do_reset();
    chk("rst_ovld", 0, 32'(out_valid), 32'd0);
    chk("rst_prd", 0, 32'(out_prd), 32'd0);
    chk("rst_imm", 0, out_imm, 32'd0);
    chk("rst_irdy", 0, 32'(in_ready), 32'd1);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].vld, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].wr, vecs[i].ordy, 1'b0, 6'd0);
      in_imm = vecs[i].imm; in_ctrl = vecs[i].ctrl;
      #1 chk("v_irdy", i, 32'(in_ready), 32'(vecs[i].e_irdy));
      @(posedge clk); #1;
      chk("v_ovld", i, 32'(out_valid), 32'(vecs[i].e_ovld));
      chk("v_prs1", i, 32'(out_prs1), 32'(vecs[i].e_prs1));
      chk("v_prs2", i, 32'(out_prs2), 32'(vecs[i].e_prs2));
      chk("v_prd", i, 32'(out_prd), 32'(vecs[i].e_prd));
      chk("v_old", i, 32'(out_old_prd), 32'(vecs[i].e_old));
      chk("v_rdwr", i, 32'(out_rd_wr), 32'(vecs[i].e_wr));
      chk("v_imm", i, out_imm, vecs[i].e_imm);
      chk("v_ctrl", i, 32'(out_ctrl), 32'(vecs[i].e_ctrl));
    end
    in_imm = '0; in_ctrl = '0;

    // Exhaust the free list, then a free unblocks the stalled allocation one cycle later.
    do_reset();
    for (int i = 0; i < 32; i++)
      alloc_step("fill", i, 5'((i % 31) + 1), 1'b1, 6'(32 + i));
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 6'd3);
    #1 chk("empty_irdy", 0, 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("empty_ovld", 0, 32'(out_valid), 32'd0);
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 6'd0);
    #1 chk("refill_irdy", 0, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("refill_ovld", 0, 32'(out_valid), 32'd1);
    chk("refill_prd", 0, 32'(out_prd), 32'd3);
    chk("refill_old", 0, 32'(out_old_prd), 32'd36);

    // Dispatch back-pressure for four cycles.
    do_reset();
    @(negedge clk);
    drive(1'b1, 5'd7, 5'd8, 5'd1, 1'b1, 1'b0, 1'b0, 6'd0);
    #1 chk("stall_irdy0", 0, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("stall_prd0", 0, 32'(out_prd), 32'd32);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 5'd1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 6'd0);
      #1 chk("stall_irdy", i, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk("stall_ovld", i, 32'(out_valid), 32'd1);
      chk("stall_prd", i, 32'(out_prd), 32'd32);
      chk("stall_prs1", i, 32'(out_prs1), 32'd7);
      chk("stall_old", i, 32'(out_old_prd), 32'd1);
    end
    @(negedge clk);
    drive(1'b1, 5'd1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 6'd0);
    #1 chk("release_irdy", 0, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("release_prd", 0, 32'(out_prd), 32'd33);
    chk("release_prs1", 0, 32'(out_prs1), 32'd32);

    // count==1 with simultaneous alloc and free, then reset mid-stream.
    do_reset();
    for (int i = 0; i < 31; i++)
      alloc_step("fill31", i, 5'((i % 31) + 1), 1'b1, 6'(32 + i));
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b1, 6'd5);
    #1 chk("same_irdy", 0, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("same_prd", 0, 32'(out_prd), 32'd63);
    chk("same_old", 0, 32'(out_old_prd), 32'd32);
    alloc_step("last", 0, 5'd2, 1'b1, 6'd5);
    chk("last_old", 0, 32'(out_old_prd), 32'd33);
    alloc_step("none", 0, 5'd3, 1'b0, 6'd0);
    @(negedge clk);
    drive(1'b1, 5'd4, 5'd0, 5'd4, 1'b0, 1'b1, 1'b0, 6'd0);
    #1 chk("nowr_irdy", 0, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("nowr_ovld", 0, 32'(out_valid), 32'd1);
    chk("nowr_prs1", 0, 32'(out_prs1), 32'd35);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 6'd0);
    @(posedge clk); #1;
    chk("mrst_ovld", 0, 32'(out_valid), 32'd0);
    chk("mrst_prs1", 0, 32'(out_prs1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 5'd5, 5'd3, 5'd1, 1'b1, 1'b1, 1'b0, 6'd0);
    #1 chk("mrst_irdy", 0, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("mrst_rat1", 0, 32'(out_prs1), 32'd5);
    chk("mrst_rat2", 0, 32'(out_prs2), 32'd3);
    chk("mrst_prd", 0, 32'(out_prd), 32'd32);
    chk("mrst_old", 0, 32'(out_old_prd), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
